mlp_banked_burst_reader: RTL
============================

// Module: mlp_banked_burst_reader
// PURPOSE
//  Burst read sequencer for MLP weights striped across NUM_BANKS M10K banks of BANK_DEPTH words each.
//  Logical address space 0..TOTAL-1, TOTAL = NUM_BANKS*BANK_DEPTH; bank b holds b*BANK_DEPTH..(b+1)*BANK_DEPTH-1.
//  On start: walks burst_len consecutive logical addresses, drives per-bank read enables/addresses,
//  realigns fixed-latency bank data, streams words out over valid/ready. Sits between weight M10Ks and MAC array.
// PARAMETERS
//  NUM_BANKS     3    number of M10K banks (>=1)
//  BANK_DEPTH    25   words per bank (>=2)
//  DATA_W        27   word width
//  READ_LATENCY  2    cycles from bank_rd_en to valid bank_rdata (>=1)
//  FIFO_DEPTH    4    output FIFO entries; must be >= READ_LATENCY+2
//  Derived: AW=$clog2(TOTAL), BAW=$clog2(BANK_DEPTH), LW=$clog2(TOTAL+1)
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 synchronous, active-high reset
//  start        in   1                 burst request; sampled only in IDLE
//  start_addr   in   AW                first logical address
//  burst_len    in   LW                words to read (0..TOTAL)
//  busy         out  1                 burst in progress
//  done         out  1                 1-cycle pulse: burst complete
//  err          out  1                 1-cycle pulse: request rejected (out of range)
//  bank_rd_en   out  NUM_BANKS         one-hot read enable, at most one bit per cycle
//  bank_addr    out  BAW               word offset within selected bank
//  bank_rdata   in   NUM_BANKS*DATA_W  bank b data on [b*DATA_W +: DATA_W]
//  out_data     out  DATA_W            streamed weight word
//  out_valid    out  1                 out_data valid
//  out_ready    in   1                 consumer accepts when valid&&ready
//  out_last     out  1                 qualifies final word of burst
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, latency pipe tags invalid; in-flight reads discarded.
//  FSM IDLE->ISSUE->DRAIN->IDLE. start ignored outside IDLE.
//  IDLE+start: reject if start_addr>=TOTAL or start_addr+burst_len>TOTAL (LW+1-bit sum): err=1 next cycle, stay IDLE, no rd_en.
//  IDLE+start, burst_len==0: done=1 next cycle, no reads, no output, busy stays 0.
//  Else: decode start_addr into (bank, offset) by repeated compare, no divider; busy=1 from next cycle; go ISSUE.
//  ISSUE: issue one read per cycle when credit ok: inflight+fifo_count < FIFO_DEPTH (registered values).
//   Issue = bank_rd_en[bank]=1, bank_addr=offset; push tag {bank,last} into READ_LATENCY-stage valid pipe.
//   Advance: offset==BANK_DEPTH-1 -> offset=0, bank+1; else offset+1. After last issue -> DRAIN.
//   bank_rd_en=0 on non-issue cycles; bank_addr holds last value.
//  Capture: tag exits pipe in cycle t+READ_LATENCY for issue in cycle t; that cycle bank_rdata slice[tag.bank]
//   and tag.last written to FIFO. First-word fall-through: out_valid from cycle after write.
//  Output: out_data/out_last stable while out_valid&&!out_ready. Words in strict address order, no loss/dup.
//  DRAIN: when handshake on out_last word occurs -> done=1 next cycle, busy=0 same cycle as done, IDLE.
//  Latency: start cycle 0 -> first rd_en cycle 1 -> first out_valid cycle READ_LATENCY+2.
//  Throughput: out_ready held 1 -> one word per cycle, no bubbles after first word.
//  Simultaneous FIFO write and pop: both occur, count unchanged. Credit guarantees no FIFO overflow.
//  rst mid-burst: abort immediately, outputs 0 next cycle; next start behaves as from reset.
// TESTING
//  T1 reset: rst high 3 cycles mid-random traffic -> all outputs 0, no rd_en, out_valid=0.
//  T2 bank crossing (defaults): start_addr=20,len=10 -> rd_en[0] offsets 20..24, rd_en[1] offsets 0..4;
//     10 words match model in order, out_last on 10th only, done 1 cycle after its handshake.
//  T3 throughput: start_addr=0,len=75,out_ready=1 -> first out_valid cycle 4, 75 consecutive words, rd_en[2] for addr 50..74.
//  T4 backpressure: len=75, out_ready random 50% and 8-cycle stall -> all 75 words in order, data stable while stalled,
//     inflight+count never > 4.
//  T5 errors/edges: (70,6)->err pulse, no rd_en; (75,1)->err; (74,1)->one word bank2 offset 24 with last;
//     len=0->done only; start while busy ignored.
//  T6 reset mid-burst + param sweep: rst at word 5 of len=30 -> clean abort, next burst correct;
//     repeat T2-T4 with NUM_BANKS=4,BANK_DEPTH=16,READ_LATENCY=3,FIFO_DEPTH=5.

Source files
------------

// File: rtl/mlp_banked_burst_reader.sv
// Burst read sequencer for MLP weights striped across M10K banks.
// Issues one bank read per cycle under FIFO credit and realigns fixed-latency data into a valid/ready stream.
module mlp_banked_burst_reader #(
  parameter int NUM_BANKS    = 3,
  parameter int BANK_DEPTH   = 25,
  parameter int DATA_W       = 27,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int TOTAL = NUM_BANKS * BANK_DEPTH,
  localparam int AW    = $clog2(TOTAL),
  localparam int BAW   = $clog2(BANK_DEPTH),
  localparam int LW    = $clog2(TOTAL + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [AW-1:0]               start_addr,
  input  logic [LW-1:0]               burst_len,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [NUM_BANKS-1:0]        bank_rd_en,
  output logic [BAW-1:0]              bank_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
);

  localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = $clog2(READ_LATENCY + 1);
  localparam int CRW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int SW  = LW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_next;

  logic [BW-1:0]  bank_q;
  logic [BAW-1:0] offset_q;
  logic [BAW-1:0] addr_hold_q;
  logic [LW-1:0]  remaining_q;
  logic [BW-1:0]  dec_bank;
  logic [BAW-1:0] dec_offset;

  logic range_err, accept, issue, issue_last, credit_ok, capture, pop;
  logic done_d, err_d, done_q, err_q;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [BW-1:0]           pipe_bank [READ_LATENCY];
  logic [IW-1:0]           inflight_q;

  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] cap_data;

  // Widened sum so start_addr + burst_len cannot wrap past TOTAL.
  assign range_err  = (SW'(start_addr) >= SW'(TOTAL)) ||
                      ((SW'(start_addr) + SW'(burst_len)) > SW'(TOTAL));
  assign issue_last = (remaining_q == LW'(1));
  assign credit_ok  = (CRW'(inflight_q) + CRW'(fifo_count)) < CRW'(FIFO_DEPTH);
  assign capture    = pipe_vld[READ_LATENCY-1];
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? fifo_mem[rd_ptr][DATA_W-1:0] : '0;
  assign out_last   = out_valid && fifo_mem[rd_ptr][DATA_W];
  assign done       = done_q;
  assign err        = err_q;

  // Bank/offset split by comparing against each bank base; no divider.
  always_comb begin
    dec_bank   = '0;
    dec_offset = BAW'(start_addr);
    for (int b = 1; b < NUM_BANKS; b++) begin
      if (SW'(start_addr) >= SW'(b * BANK_DEPTH)) begin
        dec_bank   = BW'(b);
        dec_offset = BAW'(SW'(start_addr) - SW'(b * BANK_DEPTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_next = state;
    done_d     = 1'b0;
    err_d      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_err) begin
            err_d = 1'b1;
          end else if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue && issue_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) begin
          done_d     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // bank_addr keeps the last issued offset on cycles without a read.
  always_comb begin
    busy       = (state != IDLE);
    issue      = (state == ISSUE) && credit_ok;
    bank_rd_en = '0;
    bank_addr  = addr_hold_q;
    if (issue) begin
      bank_rd_en[bank_q] = 1'b1;
      bank_addr          = offset_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= '0;
      offset_q    <= '0;
      addr_hold_q <= '0;
      remaining_q <= '0;
    end else if (accept) begin
      bank_q      <= dec_bank;
      offset_q    <= dec_offset;
      remaining_q <= burst_len;
    end else if (issue) begin
      addr_hold_q <= offset_q;
      remaining_q <= remaining_q - 1'b1;
      if (offset_q == BAW'(BANK_DEPTH - 1)) begin
        offset_q <= '0;
        bank_q   <= bank_q + 1'b1;
      end else begin
        offset_q <= offset_q + 1'b1;
      end
    end
  end

  // Tag pipe mirrors bank latency so the matching slice is captured when its data lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld   <= '0;
      inflight_q <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) pipe_vld[i] <= pipe_vld[i-1];
      pipe_vld[0] <= issue;
      inflight_q  <= inflight_q + IW'(issue) - IW'(capture);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      pipe_bank[i] <= pipe_bank[i-1];
      pipe_last[i] <= pipe_last[i-1];
    end
    pipe_bank[0] <= bank_q;
    pipe_last[0] <= issue_last;
  end

  always_comb begin
    cap_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (pipe_bank[READ_LATENCY-1] == BW'(b)) cap_data = bank_rdata[b*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) fifo_mem[wr_ptr] <= {pipe_last[READ_LATENCY-1], cap_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
